sobel_binarize: RTL and testbench
=================================

Name: sobel_binarize

Overview:
- Edge-detection stage directly upstream of the erosion stage.
- Consumes the VGA-timed 8-bit grayscale stream and works on the same 2x-downsampled grid (WIDTH x HEIGHT samples, one per even hcount on even vcount lines).
- Computes the 3x3 Sobel gradient magnitude |Gx|+|Gy|, compares it against a runtime threshold, and emits the 1-bit edge map that feeds the erosion stage.

Parameters:
- Hor_Addr_Time, 800, visible horizontal pixels of VGA timing.
- WIDTH, Hor_Addr_Time>>1, samples per downsampled row.
- Ver_Addr_Time, 600, visible lines of VGA timing.
- HEIGHT, Ver_Addr_Time>>1, downsampled rows per frame.

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-low
- hcount  in  11  VGA horizontal counter
- vcount  in  11  VGA vertical counter
- gray_value  in  8  grayscale pixel at (hcount,vcount)
- thresh  in  11  edge threshold, sampled by the magnitude stage
- sobel_value  out  1  binarized edge for the current window centre, held between updates
- sobel_valid  out  1  one-cycle pulse when sobel_value updates

Behaviour:
- Reset: rst==0 at a clock edge clears window registers, pipeline registers, sobel_value=0 and sobel_valid=0. Line-buffer contents are not reset; border masking hides stale data. Reset mid-frame drops in-flight results; no sobel_valid for 3 edges after rst returns high.
- Strobe: strobe = ~hcount[0] & ~vcount[0] & (hcount < 2*WIDTH) & (vcount < 2*HEIGHT).
  - Sample coordinates: x = hcount>>1, y = vcount>>1.
  - No strobe means no state change in the buffers or the window.
- Line buffers: two arrays of WIDTH x 8 bits. lb1 holds row y-1, lb2 holds row y-2, both with combinational read at index x. On a strobe edge:
  - lb2[x] <= lb1[x]
  - lb1[x] <= gray_value
  - The window shifts one column left; the new right column is {top=lb2[x], mid=lb1[x], bot=gray_value}.
- Window: p0..p8 row-major, p0 top-left, p8 bottom-right. Centre p4 corresponds to (x-1, y-1) of the strobe that loaded it.
- Stage 1 (edge after the window load):
  - Gx = (p2+2p5+p8) - (p0+2p3+p6)
  - Gy = (p6+2p7+p8) - (p0+2p1+p2)
  - Each partial sum is 10-bit unsigned (max 1020); Gx and Gy are 11-bit signed.
  - The border flag is registered with them: border = (x<2) | (y<2), using the strobe's x and y.
- Stage 2 (next edge):
  - mag = |Gx|+|Gy|, 11-bit unsigned (max 2040, no saturation needed).
  - sobel_value <= border ? 0 : (mag > thresh). The comparison is strict; mag==thresh gives 0.
  - sobel_valid <= 1 for exactly one cycle.
- Latency: a strobe in cycle t causes sobel_value and sobel_valid to change at the 3rd rising edge after cycle t. Throughput is one result per 2 clocks. The last pipeline result of a row completes during hcount 2*WIDTH..2*WIDTH+5; blanking does not flush or clear it.
- Coverage: window centres span columns 0..WIDTH-2 and rows 0..HEIGHT-2; column WIDTH-1 and row HEIGHT-1 are never centres.
- Frame wrap: line buffers carry over from the previous frame. Rows y<2 of the new frame are masked to 0.
- thresh may change at any time and takes effect on the next stage-2 update.

Test Plan:
- Uniform frame, gray=100, thresh=0: every sobel_valid pulse carries sobel_value=0 (mag=0, not >0). Pulse count per frame = WIDTH*HEIGHT.
- Vertical step, gray=0 for x<10 and 255 for x>=10, thresh=500: for rows y>=2 in a row, centre columns 9 and 10 give 1 (Gx=1020) and all other centres give 0.
- Horizontal step, gray=0 for y<20 and 255 for y>=20, thresh=500: centre rows 19 and 20 are all 1 for centre columns >=1, all other rows are 0. Column-0 centres are masked to 0.
- Threshold edge, vertical step with amplitude 50 (Gx=200): thresh=200 gives 0 and thresh=199 gives 1 at centres 9 and 10.
- Latency and border: a single strobe at hcount=20, vcount=4 (x=10, y=2) gives sobel_valid exactly 3 edges later. Strobes with x<2 or y<2 always give 0, even with a high-contrast input.
- Reset: assert rst=0 for 1 cycle mid-row during a vertical-step frame. Outputs read 0 next cycle, no valid pulse for 3 edges after release, and correct edges resume from the following row.

Source files
------------

// File: rtl/sobel_binarize.sv
// sobel_binarize
//   3x3 Sobel edge detector on the 2x-downsampled VGA grayscale stream.
//   One sample per even hcount on even vcount lines (WIDTH x HEIGHT grid).
//   The result is |Gx|+|Gy| compared against a runtime threshold and emitted
//   as a 1-bit edge map for the erosion stage.
// Ports:
//   clk          pixel clock
//   rst          synchronous, active-low reset
//   hcount       VGA horizontal counter
//   vcount       VGA vertical counter
//   gray_value   8-bit grayscale pixel at (hcount, vcount)
//   thresh       edge threshold, sampled at the magnitude stage
//   sobel_value  binarized edge for the current window centre, held between updates
//   sobel_valid  one-cycle pulse when sobel_value updates
module sobel_binarize #(
  parameter int Hor_Addr_Time = 800,
  parameter int WIDTH         = Hor_Addr_Time >> 1,
  parameter int Ver_Addr_Time = 600,
  parameter int HEIGHT        = Ver_Addr_Time >> 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic [7:0]  gray_value,
  input  logic [10:0] thresh,
  output logic        sobel_value,
  output logic        sobel_valid
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic          strobe;
  logic [9:0]    x, y;
  logic [XW-1:0] xi;

  assign x  = hcount[10:1];
  assign y  = vcount[10:1];
  assign xi = x[XW-1:0];
  assign strobe = ~hcount[0] & ~vcount[0] &
                  (hcount < 11'(2 * WIDTH)) & (vcount < 11'(2 * HEIGHT));

  // Line buffers: lb1 = row y-1, lb2 = row y-2. Not reset; the border mask
  // hides whatever they hold at the top of a frame. They keep updating on
  // strobes during reset so the rows after a mid-frame reset see valid data.
  logic [7:0] lb1 [WIDTH];
  logic [7:0] lb2 [WIDTH];
  logic [7:0] top, mid;

  assign top = lb2[xi];
  assign mid = lb1[xi];

  always_ff @(posedge clk) begin
    if (strobe) begin
      lb2[xi] <= mid;
      lb1[xi] <= gray_value;
    end
  end

  // Window p0..p8, row-major, p0 top-left.
  logic [8:0][7:0] win;

  // Partial sums, each at most 4*255 = 1020.
  logic [9:0] sx_r, sx_l, sy_b, sy_t;
  assign sx_r = {2'b0, win[2]} + {1'b0, win[5], 1'b0} + {2'b0, win[8]};
  assign sx_l = {2'b0, win[0]} + {1'b0, win[3], 1'b0} + {2'b0, win[6]};
  assign sy_b = {2'b0, win[6]} + {1'b0, win[7], 1'b0} + {2'b0, win[8]};
  assign sy_t = {2'b0, win[0]} + {1'b0, win[1], 1'b0} + {2'b0, win[2]};

  logic signed [10:0] gx_n, gy_n, gx, gy;
  assign gx_n = $signed({1'b0, sx_r}) - $signed({1'b0, sx_l});
  assign gy_n = $signed({1'b0, sy_b}) - $signed({1'b0, sy_t});

  // |G| never exceeds 1020, so the sum of the two fits in 11 bits unsaturated.
  logic [10:0] abs_gx, abs_gy, mag;
  assign abs_gx = gx[10] ? 11'(-gx) : 11'(gx);
  assign abs_gy = gy[10] ? 11'(-gy) : 11'(gy);
  assign mag    = abs_gx + abs_gy;

  // vld_pipe[0]: window freshly loaded; vld_pipe[1]: gradients registered.
  logic [1:0] vld_pipe;
  logic       brd0, brd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      win         <= '0;
      vld_pipe    <= '0;
      brd0        <= 1'b0;
      brd1        <= 1'b0;
      gx          <= '0;
      gy          <= '0;
      sobel_value <= 1'b0;
      sobel_valid <= 1'b0;
    end else begin
      vld_pipe    <= {vld_pipe[0], strobe};
      sobel_valid <= vld_pipe[1];
      if (strobe) begin
        win  <= {gray_value, win[8:7], mid, win[5:4], top, win[2:1]};
        // Border uses the strobe's coordinates; centre is one behind in x and y.
        brd0 <= (x < 10'd2) | (y < 10'd2);
      end
      if (vld_pipe[0]) begin
        gx   <= gx_n;
        gy   <= gy_n;
        brd1 <= brd0;
      end
      if (vld_pipe[1])
        sobel_value <= brd1 ? 1'b0 : (mag > thresh);
    end
  end

endmodule

// File: tb/tb_sobel_binarize.sv
module tb_sobel_binarize;
  localparam int HA = 64, VA = 48;
  localparam int W = HA >> 1, H = VA >> 1;
  localparam int HT = 80, VT = 52;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hcount = '0, vcount = '0;
  logic [7:0]  gray_value = '0;
  logic [10:0] thresh = '0;
  logic        sobel_value, sobel_valid;

  sobel_binarize #(.Hor_Addr_Time(HA), .Ver_Addr_Time(VA)) dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
    .gray_value(gray_value), .thresh(thresh),
    .sobel_value(sobel_value), .sobel_valid(sobel_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int due; bit val; bit dc; } exp_t;
  exp_t sbq[$];
  exp_t e;

  int checks = 0, failures = 0;
  int edge_n = 0, pulses = 0, ones = 0;
  int mode = 0, amp = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Test image: 0 uniform, 1 vertical step at x=10, 2 horizontal step at y=20.
  function automatic int pix(input int px, input int py);
    case (mode)
      0: return amp;
      1: return (px >= 10) ? amp : 0;
      default: return (py >= 20) ? amp : 0;
    endcase
  endfunction

  // Reference Sobel on the image, for the window whose last column is (sx, sy).
  function automatic bit model(input int sx, input int sy, input int th);
    int cx, cy, gxm, gym, mg;
    if (sx < 2 || sy < 2) return 1'b0;
    cx = sx - 1; cy = sy - 1;
    gxm = (pix(cx+1,cy-1) + 2*pix(cx+1,cy) + pix(cx+1,cy+1))
        - (pix(cx-1,cy-1) + 2*pix(cx-1,cy) + pix(cx-1,cy+1));
    gym = (pix(cx-1,cy+1) + 2*pix(cx,cy+1) + pix(cx+1,cy+1))
        - (pix(cx-1,cy-1) + 2*pix(cx,cy-1) + pix(cx+1,cy-1));
    mg = (gxm < 0 ? -gxm : gxm) + (gym < 0 ? -gym : gym);
    return mg > th;
  endfunction

  // Monitor: sample 1 time unit after the active edge.
  always @(posedge clk) begin
    edge_n++;
    #1;
    if (!rst) begin
      chk("rst_valid", sobel_valid, 0);
      chk("rst_value", sobel_value, 0);
      sbq.delete();
    end else if (sobel_valid) begin
      pulses++;
      if (sobel_value) ones++;
      if (sbq.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("latency", edge_n, e.due);
        if (!e.dc) chk("edge_value", sobel_value, e.val);
      end
    end
  end

  // One full VGA-timed frame; optional one-cycle reset at (hcount=40, vcount=rst_v).
  task automatic drive_frame(input int m, input int a, input int th, input int rst_v);
    bit dc;
    int px, py;
    bit vis, strb;
    mode = m; amp = a;
    dc = 1'b0;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        @(negedge clk);
        if (h == 0) dc = 1'b0;
        px = h >> 1; py = v >> 1;
        vis = (h < 2*W) && (v < 2*H);
        strb = vis && (h % 2 == 0) && (v % 2 == 0);
        hcount = 11'(h); vcount = 11'(v); thresh = 11'(th);
        gray_value = vis ? 8'(pix(px, py)) : 8'd0;
        rst = !(v == rst_v && h == 40);
        if (!rst) dc = 1'b1;  // rest of this row sees a cleared window
        if (strb && rst) sbq.push_back('{edge_n + 3, model(px, py, th), dc});
      end
    end
  endtask

  task automatic single_strobe(input int h, input int v, input bit dc);
    @(negedge clk);
    hcount = 11'(h); vcount = 11'(v); gray_value = 8'd255; rst = 1'b1;
    sbq.push_back('{edge_n + 3, model(h >> 1, v >> 1, thresh), dc});
    @(negedge clk);
    hcount = 11'(h + 1);
    repeat (6) @(negedge clk);
  endtask

  int p0, o0;

  initial begin
    hcount = 11'd1;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Uniform: never an edge, one pulse per sample.
    p0 = pulses; o0 = ones;
    drive_frame(0, 100, 0, -1);
    chk("uniform_pulses", pulses - p0, W * H);
    chk("uniform_ones", ones - o0, 0);

    // Vertical step: centres 9 and 10 on rows 1..H-2 -> 2*(H-2).
    o0 = ones;
    drive_frame(1, 255, 500, -1);
    chk("vstep_ones", ones - o0, 2 * (H - 2));

    // Horizontal step: centre rows 19, 20, columns 1..W-2.
    o0 = ones;
    drive_frame(2, 255, 500, -1);
    chk("hstep_ones", ones - o0, 2 * (W - 2));

    // Threshold boundary: Gx = 200.
    o0 = ones;
    drive_frame(1, 50, 200, -1);
    chk("thresh_eq_ones", ones - o0, 0);
    o0 = ones;
    drive_frame(1, 50, 199, -1);
    chk("thresh_lt_ones", ones - o0, 2 * (H - 2));

    // Mid-row reset during a vertical-step frame.
    drive_frame(1, 255, 500, 20);

    // Isolated strobes: latency, then border masking with high contrast.
    mode = 1; amp = 255;
    single_strobe(20, 4, 1'b1);
    single_strobe(2, 10, 1'b0);
    single_strobe(30, 2, 1'b0);

    repeat (10) @(negedge clk);
    chk("queue_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
